decomp_output: RTL and testbench
================================

DECOMP_OUTPUT -- requirements
Module: decomp_output

Interface
REQ-001 SHALL have parameter HISTORY, default 4096, history window depth in bytes (power of two, 12-bit offsets).
REQ-002 SHALL have parameter MIN_MATCH, default 3, added to the tok_length field to give the copy length.
REQ-003 clock  input  1  clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 tok_valid  input  1  token present.
REQ-006 tok_ready  output  1  token accepted when tok_valid && tok_ready at posedge.
REQ-007 tok_is_copy  input  1  1 = copy token, 0 = literal.
REQ-008 tok_literal  input  8  literal byte (literal tokens only).
REQ-009 tok_offset  input  12  copy distance back from next write position, 1..4095.
REQ-010 tok_length  input  4  copy length minus MIN_MATCH (copy length 3..18).
REQ-011 out_valid  output  1  out_byte valid.
REQ-012 out_ready  input  1  sink accepts out_byte when out_valid && out_ready.
REQ-013 out_byte  output  8  decompressed byte.
REQ-014 err  output  1  sticky illegal-offset flag.
REQ-015 byte_count  output  32  bytes produced since reset, wraps mod 2^32.

Function
REQ-016 "Produce" SHALL mean: load the output register and write the same byte to history[wptr], then increment wptr mod HISTORY and byte_count; produce is allowed only when !out_valid || out_ready.
REQ-017 out_valid SHALL stay high with out_byte stable until out_ready; it clears when out_ready is high and no byte is produced that cycle.
REQ-018 FSM states SHALL be IDLE and COPY.
REQ-019 In IDLE, tok_ready SHALL equal (!out_valid || out_ready); in COPY, tok_ready SHALL be 0.
REQ-020 A literal accepted at edge N SHALL be produced at edge N (out_valid high after N); the FSM stays in IDLE.
REQ-021 A legal copy accepted at edge N SHALL latch src = (wptr - tok_offset) mod HISTORY and rem = tok_length + MIN_MATCH, and move to COPY; no byte is produced at N.
REQ-022 In COPY, each cycle where produce is allowed SHALL produce history[src] (combinational read), then increment src mod HISTORY and decrement rem.
REQ-023 When the byte with rem == 1 is produced, the FSM SHALL return to IDLE.
REQ-024 Without backpressure, a copy accepted at N SHALL yield bytes at edges N+1 .. N+len, one per cycle.
REQ-025 Overlapping copies (offset < length) SHALL replicate data byte-by-byte, because a byte written at edge t is readable at edge t+1.
REQ-026 A copy SHALL be illegal when tok_offset == 0, or when byte_count < 4096 and tok_offset > byte_count.
REQ-027 An illegal copy SHALL be consumed, set err, produce no bytes, and leave the FSM in IDLE.
REQ-028 err SHALL clear only on reset.
REQ-029 wptr and src SHALL wrap from HISTORY-1 to 0 without a stall or bubble.

Reset
REQ-030 On reset, out_valid, err, byte_count, wptr, src and rem SHALL become 0, and the FSM SHALL go to IDLE.
REQ-031 Reset during COPY SHALL abort the copy; bytes not yet produced are discarded.
REQ-032 History contents SHALL NOT be cleared on reset; REQ-026 guarantees unwritten entries are never read.
REQ-033 tok_ready SHALL be 1 in the first cycle after reset is deasserted.

Structure
REQ-034 Package lzrw1_pkg SHALL hold HISTORY, MIN_MATCH, the offset/length widths and a token struct typedef shared with the compressor.
REQ-035 Sub-module decomp_history SHALL implement the HISTORY x 8 store: one synchronous write port, one combinational read port.
REQ-036 The FSM, pointers, error check and output register SHALL reside in decomp_output.

Verification
REQ-037 Literals 0x41,0x42,0x43 on consecutive cycles, out_ready=1 -> out_byte 41,42,43 on consecutive cycles; byte_count=3.
REQ-038 Literals "AB" then copy offset=2, length=4 (len 7) -> ABABABABA, copy bytes one per cycle starting one cycle after acceptance.
REQ-039 Copy offset=1, length=0 after literal 0x5A -> three bytes 0x5A; tok_ready low for exactly 3 cycles.
REQ-040 Copy offset=5 issued when byte_count=2 -> err=1, no out_valid, byte_count stays 2, next literal still accepted and emitted.
REQ-041 out_ready held low for 4 cycles mid-copy -> out_byte stable during the stall, no byte lost or duplicated, tok_ready=0 throughout.
REQ-042 4100 literals then copy offset=4095 -> reads across wptr wrap return the byte written 4095 positions earlier; reset mid-copy -> out_valid=0 next cycle.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 definitions: window geometry, token fields and decompressor FSM states.
package lzrw1_pkg;

    localparam int unsigned HISTORY   = 4096;
    localparam int unsigned MIN_MATCH = 3;
    localparam int unsigned OFF_W     = 12;
    localparam int unsigned LEN_W     = 4;

    typedef struct packed {
        logic             is_copy;
        logic [7:0]       literal;
        logic [OFF_W-1:0] offset;
        logic [LEN_W-1:0] length;
    } token_t;

    typedef enum logic {
        StIdle,
        StCopy
    } state_e;

endpackage

// File: rtl/decomp_history.sv
// History window: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the offset check keeps stale entries unreachable.
module decomp_history #(
    parameter int unsigned HISTORY = 4096,
    parameter int unsigned AddrW   = $clog2(HISTORY)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem [HISTORY];

    // Write the produced byte into the window
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/decomp_output.sv
// LZRW1 decompressor back end: expands literal/copy tokens into a byte stream.
module decomp_output #(
    parameter int unsigned HISTORY   = lzrw1_pkg::HISTORY,
    parameter int unsigned MIN_MATCH = lzrw1_pkg::MIN_MATCH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tok_valid_i,
    output logic                       tok_ready_o,
    input  logic                       tok_is_copy_i,
    input  logic [7:0]                 tok_literal_i,
    input  logic [lzrw1_pkg::OFF_W-1:0] tok_offset_i,
    input  logic [lzrw1_pkg::LEN_W-1:0] tok_length_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [7:0]                 out_byte_o,
    output logic                       err_o,
    output logic [31:0]                byte_count_o
);
    import lzrw1_pkg::*;

    localparam int unsigned AW   = $clog2(HISTORY);
    localparam int unsigned RemW = LEN_W + 1;

    token_t          tok;
    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   src_q, src_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_byte_q, out_byte_d;
    logic            err_q, err_d;
    logic [31:0]     count_q, count_d;
    logic            can_produce;
    logic            produce;
    logic [7:0]      prod_byte;
    logic [7:0]      hist_rdata;
    logic            copy_illegal;

    assign tok = '{is_copy: tok_is_copy_i, literal: tok_literal_i,
                   offset: tok_offset_i, length: tok_length_i};

    // The output register can take a new byte if it is empty or being drained this cycle
    assign can_produce = !out_valid_q || out_ready_i;

    // Offsets reaching before the first byte since reset would read unwritten history
    assign copy_illegal = (tok.offset == '0) ||
                          ((count_q < 32'(HISTORY)) && (32'(tok.offset) > count_q));

    decomp_history #(
        .HISTORY (HISTORY),
        .AddrW   (AW)
    ) u_history (
        .clock   (clock),
        .we_i    (produce),
        .waddr_i (wptr_q),
        .wdata_i (prod_byte),
        .raddr_i (src_q),
        .rdata_o (hist_rdata)
    );

    // Token decode, copy sequencing and output-register handshake
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        src_d       = src_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        err_d       = err_q;
        count_d     = count_q;
        produce     = 1'b0;
        prod_byte   = tok.literal;
        tok_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                tok_ready_o = can_produce;
                if (tok_valid_i && can_produce) begin
                    if (!tok.is_copy) begin
                        produce   = 1'b1;
                        prod_byte = tok.literal;
                    end else if (copy_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        src_d   = wptr_q - AW'(tok.offset);
                        rem_d   = RemW'(tok.length) + RemW'(MIN_MATCH);
                        state_d = StCopy;
                    end
                end
            end
            StCopy: begin
                if (can_produce) begin
                    produce   = 1'b1;
                    prod_byte = hist_rdata;
                    src_d     = src_q + AW'(1);
                    rem_d     = rem_q - RemW'(1);
                    if (rem_q == RemW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (produce) begin
            out_valid_d = 1'b1;
            out_byte_d  = prod_byte;
            wptr_d      = wptr_q + AW'(1);
            count_d     = count_q + 32'd1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset also aborts any copy in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            src_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            src_q       <= src_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_byte_o   = out_byte_q;
    assign err_o        = err_q;
    assign byte_count_o = count_q;

endmodule

// File: tb/tb_decomp_output.sv
// Self-checking bench for decomp_output against a byte-stream reference model.
module tb_decomp_output;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tok_valid_i = 1'b0;
    logic        tok_ready_o;
    logic        tok_is_copy_i = 1'b0;
    logic [7:0]  tok_literal_i = '0;
    logic [11:0] tok_offset_i = '0;
    logic [3:0]  tok_length_i = '0;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_byte_o;
    logic        err_o;
    logic [31:0] byte_count_o;

    logic        bp_en = 1'b0;
    logic        bp_bit = 1'b1;
    logic        ready_ctl = 1'b1;
    assign out_ready_i = bp_en ? bp_bit : ready_ctl;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    // Reference model: every byte produced since reset, and the stream still expected
    logic [7:0]  mhist[$];
    logic [7:0]  exp_q[$];
    int unsigned mcount = 0;
    bit          merr = 1'b0;

    logic [7:0]  got[$];
    int unsigned got_t[$];

    decomp_output #(
        .HISTORY   (4096),
        .MIN_MATCH (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tok_valid_i   (tok_valid_i),
        .tok_ready_o   (tok_ready_o),
        .tok_is_copy_i (tok_is_copy_i),
        .tok_literal_i (tok_literal_i),
        .tok_offset_i  (tok_offset_i),
        .tok_length_i  (tok_length_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_byte_o    (out_byte_o),
        .err_o         (err_o),
        .byte_count_o  (byte_count_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        bp_bit = ($urandom_range(0, 3) != 0);
    end

    // A byte seen valid and ready here transfers at the next rising edge
    always @(negedge clock) begin
        if (!reset && out_valid_o && out_ready_i) begin
            got.push_back(out_byte_o);
            got_t.push_back(cyc);
        end
    end

    task automatic model_clear();
        mhist.delete();
        exp_q.delete();
        got.delete();
        got_t.delete();
        mcount = 0;
        merr = 1'b0;
    endtask

    task automatic model_tok(input bit is_copy, input logic [7:0] lit, input int off,
                             input int len);
        if (!is_copy) begin
            mhist.push_back(lit);
            exp_q.push_back(lit);
        end else if (off == 0 || (mcount < 4096 && off > int'(mcount))) begin
            merr = 1'b1;
        end else begin
            for (int i = 0; i < len + 3; i++) begin
                logic [7:0] b;
                b = mhist[mhist.size() - off];
                mhist.push_back(b);
                exp_q.push_back(b);
            end
        end
        mcount = mhist.size();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_tok(input bit is_copy, input logic [7:0] lit, input int off,
                            input int len, output int unsigned acc);
        int n;
        n = 0;
        tok_valid_i   = 1'b1;
        tok_is_copy_i = is_copy;
        tok_literal_i = lit;
        tok_offset_i  = 12'(off);
        tok_length_i  = 4'(len);
        @(negedge clock);
        while (!tok_ready_o && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!tok_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_tok: tok_ready never rose within %0d cycles", n);
        end
        @(posedge clock);
        #1;
        acc = cyc;
        tok_valid_i = 1'b0;
        if (n < 500) model_tok(is_copy, lit, off, len);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic drain_check(input string name);
        int n;
        int lim;
        n = 0;
        while (got.size() < exp_q.size() && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s byte_total: got %0d bytes, expected %0d", name, got.size(),
                     exp_q.size());
        end
        lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s byte[%0d]: got %02h, expected %02h", name, i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (byte_count_o !== 32'(mcount)) begin
            n_fail++;
            $display("FAIL %s byte_count: got %0d, expected %0d", name, byte_count_o, mcount);
        end
        n_checks++;
        if (err_o !== merr) begin
            n_fail++;
            $display("FAIL %s err: got %0b, expected %0b", name, err_o, merr);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stream();
        got.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        n_checks++;
        if (out_valid_o !== 1'b0 || err_o !== 1'b0 || byte_count_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b err=%0b count=%0d, expected 0 0 0",
                     out_valid_o, err_o, byte_count_o);
        end
        n_checks++;
        if (tok_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tok_ready: got %0b, expected 1", tok_ready_o);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_literals();
        int unsigned acc;
        send_tok(1'b0, 8'h41, 0, 0, acc);
        send_tok(1'b0, 8'h42, 0, 0, acc);
        send_tok(1'b0, 8'h43, 0, 0, acc);
        drain_check("literals");
        for (int i = 1; i < int'(got_t.size()); i++) begin
            n_checks++;
            if (got_t[i] !== got_t[0] + i) begin
                n_fail++;
                $display("FAIL literals_timing[%0d]: cycle %0d, expected %0d", i, got_t[i],
                         got_t[0] + i);
            end
        end
        clear_stream();
    endtask

    task automatic test_copy_overlap();
        int unsigned acc;
        send_tok(1'b0, 8'h41, 0, 0, acc);
        send_tok(1'b0, 8'h42, 0, 0, acc);
        send_tok(1'b1, 8'h00, 2, 4, acc);
        drain_check("copy_abab");
        n_checks++;
        if (got_t.size() != 9 || got_t[2] !== acc + 1) begin
            n_fail++;
            $display("FAIL copy_first_byte: %0d bytes, first copy byte cycle %0d, expected 9 at %0d",
                     got_t.size(), (got_t.size() > 2) ? got_t[2] : 0, acc + 1);
        end
        for (int i = 3; i < int'(got_t.size()); i++) begin
            n_checks++;
            if (got_t[i] !== got_t[i-1] + 1) begin
                n_fail++;
                $display("FAIL copy_timing[%0d]: cycle %0d, expected %0d", i, got_t[i],
                         got_t[i-1] + 1);
            end
        end
        clear_stream();
    endtask

    task automatic test_single_offset();
        int unsigned acc;
        int lows;
        send_tok(1'b0, 8'h5A, 0, 0, acc);
        send_tok(1'b1, 8'h00, 1, 0, acc);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tok_ready_o) break;
            lows++;
        end
        n_checks++;
        if (lows != 3) begin
            n_fail++;
            $display("FAIL ready_low_cycles: got %0d, expected 3", lows);
        end
        @(posedge clock);
        #1;
        drain_check("repeat_5a");
        clear_stream();
    endtask

    task automatic test_illegal();
        int unsigned acc;
        do_reset();
        send_tok(1'b0, 8'h11, 0, 0, acc);
        send_tok(1'b0, 8'h22, 0, 0, acc);
        send_tok(1'b1, 8'h00, 5, 2, acc);
        @(negedge clock);
        n_checks++;
        if (out_valid_o !== 1'b0 || err_o !== 1'b1 || byte_count_o !== 32'd2) begin
            n_fail++;
            $display("FAIL illegal_copy: valid=%0b err=%0b count=%0d, expected 0 1 2",
                     out_valid_o, err_o, byte_count_o);
        end
        @(posedge clock);
        #1;
        send_tok(1'b0, 8'h33, 0, 0, acc);
        drain_check("after_illegal");
        clear_stream();
    endtask

    task automatic test_stall();
        int unsigned acc;
        logic [7:0] held;
        for (int i = 0; i < 3; i++) send_tok(1'b0, 8'($urandom), 0, 0, acc);
        send_tok(1'b1, 8'h00, 3, 5, acc);
        @(posedge clock);
        #1;
        ready_ctl = 1'b0;
        held = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) held = out_byte_o;
            n_checks++;
            if (out_valid_o !== 1'b1 || out_byte_o !== held || tok_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall[%0d]: valid=%0b byte=%02h ready=%0b, expected 1 %02h 0",
                         i, out_valid_o, out_byte_o, tok_ready_o, held);
            end
        end
        @(posedge clock);
        #1;
        ready_ctl = 1'b1;
        drain_check("stall_copy");
        clear_stream();
    endtask

    task automatic test_random();
        int unsigned acc;
        int sel;
        int maxoff;
        bp_en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 99);
            maxoff = (mcount < 4095) ? int'(mcount) : 4095;
            if (mcount == 0 || sel < 45) begin
                send_tok(1'b0, 8'($urandom), 0, 0, acc);
            end else if (sel < 48) begin
                send_tok(1'b1, 8'h00, (sel == 45) ? 0 : maxoff + 1, $urandom_range(0, 15), acc);
            end else begin
                send_tok(1'b1, 8'h00, $urandom_range(1, maxoff), $urandom_range(0, 15), acc);
            end
        end
        bp_en = 1'b0;
        drain_check("random");
        clear_stream();
    endtask

    task automatic test_wrap_and_abort();
        int unsigned acc;
        int n;
        do_reset();
        for (int i = 0; i < 4100; i++) send_tok(1'b0, 8'($urandom), 0, 0, acc);
        send_tok(1'b1, 8'h00, 4095, 15, acc);
        drain_check("wrap_copy");
        clear_stream();
        send_tok(1'b1, 8'h00, 100, 15, acc);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_valid: got %0b, expected 0", out_valid_o);
        end
        n = got.size();
        n_checks++;
        if (n < 1 || n >= int'(exp_q.size())) begin
            n_fail++;
            $display("FAIL abort_partial: got %0d bytes, expected between 1 and %0d", n,
                     exp_q.size() - 1);
        end
        for (int i = 0; i < n && i < int'(exp_q.size()); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_byte[%0d]: got %02h, expected %02h", i, got[i], exp_q[i]);
            end
        end
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clock);
        n_checks++;
        if (out_valid_o !== 1'b0 || byte_count_o !== 32'd0 || tok_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle: valid=%0b count=%0d ready=%0b, expected 0 0 1",
                     out_valid_o, byte_count_o, tok_ready_o);
        end
        @(posedge clock);
        #1;
        send_tok(1'b0, 8'h7E, 0, 0, acc);
        send_tok(1'b1, 8'h00, 1, 2, acc);
        drain_check("post_abort");
        clear_stream();
    endtask

    initial begin
        test_reset();
        test_literals();
        test_copy_overlap();
        test_single_offset();
        test_illegal();
        test_stall();
        test_random();
        test_wrap_and_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
